q1_fetch: RTL and testbench
===========================

Name: q1_fetch

Overview:
Instruction-fetch stage (pipeline stage 1). It owns the program counter, issues single-outstanding requests to instruction memory, and presents the fetched instruction, its PC and PC+4 to the IF/ID pipeline register through a valid/ready handshake. Redirects from later stages (branch/jump/trap) override sequential fetch and squash any in-flight response.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; first fetch address.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
redirect_i  input  1  flush and restart fetch at redirect_pc_i
redirect_pc_i  input  32  redirect target; bits [1:0] ignored, treated as 0
imem_req_o  output  1  instruction memory request
imem_addr_o  output  32  request address (word aligned)
imem_gnt_i  input  1  memory accepts the request this cycle (req & gnt)
imem_rvalid_i  input  1  read data valid; at least 1 cycle after grant
imem_rdata_i  input  32  read data
valid_o  output  1  instr_o/pc_o/pc_incr_o valid
ready_i  input  1  downstream accepts this cycle (valid_o & ready_i)
instr_o  output  32  fetched instruction
pc_o  output  32  address of instr_o
pc_incr_o  output  32  pc_o + 4, modulo 2^32

Behaviour:
- Reset (rst=1 at clk edge): pc <= RESET_PC, state <= S_REQ, kill <= 0, instruction buffer <= 32'h0. During and after reset: valid_o=0, instr_o=0, pc_o=RESET_PC, pc_incr_o=RESET_PC+4. imem_req_o=0 while rst=1. Instruction memory shares this reset; no response survives reset.
- States:
  S_REQ: imem_req_o=1, imem_addr_o=pc. req & gnt -> S_WAIT. Otherwise stay, holding address stable.
  S_WAIT: imem_req_o=0. rvalid & ~kill: capture rdata -> S_VALID. rvalid & kill: discard, clear kill -> S_REQ.
  S_VALID: valid_o=1, instr_o=buffer, pc_o=pc. ready_i: pc <= pc+4 -> S_REQ. ~ready_i: hold all outputs stable (stall).
- Latency: grant to valid_o is at least 2 cycles (rvalid cycle + capture). Throughput is at most one instruction per 3 cycles with a 1-cycle memory. Single outstanding request only.
- Redirect has highest priority, in every state:
  - pc <= {redirect_pc_i[31:2],2'b00}, next state S_REQ.
  - S_WAIT without rvalid: stay in S_WAIT with kill <= 1; the response is dropped, then go to S_REQ.
  - S_WAIT with rvalid in the same cycle: the response is discarded and kill stays 0.
  - S_REQ with gnt in the same cycle: the granted request is in flight, so go to S_WAIT with kill <= 1.
  - S_VALID: the buffered instruction is dropped and no handshake completes, even if ready_i=1.
- valid_o = (state==S_VALID) & ~redirect_i. This is combinational from the state and redirect only.
- Simultaneous ready_i and redirect_i: redirect wins and the pc+4 increment is suppressed.
- pc wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000. No fault is raised.
- Misaligned redirect: low two bits are forced to 0 and no exception is generated.
- pc_incr_o is always pc_o + 4, computed from the PC register.
- No X-propagation: instr_o holds its last captured value outside S_VALID.

Decomposition:
- Shared package holds:
  - state enum {S_REQ, S_WAIT, S_VALID}, 2-bit
  - XLEN=32
  - INSTR_BYTES=4
  - NOP_INSTR=32'h0000_0013 (used by q1q2 bubble insertion)
- One natural sub-module: q1_pc_reg, the PC register with reset to RESET_PC, an increment-by-4 adder, redirect mux and low-bit masking. It outputs pc and pc_incr.
- The FSM and instruction buffer stay in q1_fetch.

Test Plan:
- Reset release, memory grants immediately with rvalid 1 cycle later carrying 32'h0000_0013, ready_i=1 -> imem_addr_o sequence 0x0,0x4,0x8; valid_o pulses with pc_o=0x0, pc_incr_o=0x4, instr_o=0x13.
- Stall: hold ready_i=0 for 5 cycles in S_VALID with instr 32'hDEADBEEF at pc 0x8 -> outputs stable and imem_req_o=0 throughout; on ready_i=1, next request goes to 0xC.
- Redirect while in S_WAIT (rvalid arrives 3 cycles later with 32'h1111_1111), redirect_pc_i=0x100 -> that data is never presented; next request is to 0x100 and its data is presented with pc_o=0x100.
- Redirect and rvalid in the same cycle, and redirect and ready_i in the same S_VALID cycle, with redirect_pc_i=0x203 -> no handshake, next request goes to 0x200, kill does not drop the following response.
- gnt held low for 4 cycles in S_REQ -> imem_req_o and imem_addr_o stay constant; then gnt=1 proceeds normally.
- Wrap: redirect to 0xFFFFFFFC then accept -> pc_incr_o=0x0 and the next request is to 0x0. Assert rst mid-S_WAIT -> after reset the next request is to RESET_PC and valid_o=0.

Source files
------------

// File: rtl/q1_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage and its neighbours.
package q1_fetch_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/q1_pc_reg.sv
// Program counter: reset value, redirect with forced word alignment, and +4 advance.
module q1_pc_reg
  import q1_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        advance_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_incr_o
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;

  assign pc_o      = pc_q;
  assign pc_incr_o = pc_q + XLEN'(INSTR_BYTES);

  // Redirect outranks the sequential advance; misaligned targets are silently aligned.
  always_comb begin
    pc_d = pc_q;
    if (redirect_i) begin
      pc_d = redirect_pc_i & ~32'h0000_0003;
    end else if (advance_i) begin
      pc_d = pc_incr_o;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/q1_fetch.sv
// Fetch stage: single-outstanding imem requests, instruction buffer and IF/ID valid/ready output.
module q1_fetch
  import q1_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_incr_o
);

  fetch_state_e    state_q;
  fetch_state_e    state_d;
  logic            kill_q;
  logic            kill_d;
  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] instr_d;
  logic [XLEN-1:0] pc;
  logic            advance;

  q1_pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk          (clk),
    .rst          (rst),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .advance_i    (advance),
    .pc_o         (pc),
    .pc_incr_o    (pc_incr_o)
  );

  assign valid_o     = (state_q == S_VALID) && !redirect_i;
  assign advance     = valid_o && ready_i;
  assign imem_req_o  = (state_q == S_REQ) && !rst;
  assign imem_addr_o = pc;
  assign pc_o        = pc;
  assign instr_o     = instr_q;

  always_comb begin
    state_d = state_q;
    kill_d  = kill_q;
    instr_d = instr_q;
    case (state_q)
      // A grant coinciding with a redirect leaves a stale response in flight.
      S_REQ: begin
        if (imem_gnt_i) begin
          state_d = S_WAIT;
          kill_d  = redirect_i;
        end
      end
      S_WAIT: begin
        if (imem_rvalid_i) begin
          kill_d = 1'b0;
          if (kill_q || redirect_i) begin
            state_d = S_REQ;
          end else begin
            instr_d = imem_rdata_i;
            state_d = S_VALID;
          end
        end else if (redirect_i) begin
          kill_d = 1'b1;
        end
      end
      S_VALID: begin
        if (redirect_i || ready_i) begin
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      kill_q  <= 1'b0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      instr_q <= instr_d;
    end
  end

endmodule

// File: tb/tb_q1_fetch.sv
// Bench for q1_fetch: directed scenarios then random traffic against an epoch-based fetch model.
module tb_q1_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_incr_o;

  always #5 clk = ~clk;

  q1_fetch #(
    .RESET_PC(RESET_PC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_gnt_i   (imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .instr_o      (instr_o),
    .pc_o         (pc_o),
    .pc_incr_o    (pc_incr_o)
  );

  int n_asserts = 0;
  int n_fail    = 0;

  // Model: architectural pc, one buffered instruction, and an epoch that every redirect/reset bumps.
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  bit          m_have;
  int          m_epoch;

  // Memory side: at most one response pending, tagged with the epoch it was granted in.
  bit          outstanding;
  int          resp_wait;
  int          resp_epoch;
  logic [31:0] resp_data;

  bit          mem_gnt;
  int          mem_lat;
  bit          mem_fixed;
  logic [31:0] mem_fixed_val;
  bit          granted_now;
  logic [31:0] grant_addr;
  logic [31:0] glog[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit redir, input logic [31:0] rpc, input bit rdy);
    bit exp_req;
    bit got;
    bit fire;
    @(negedge clk);
    rst           = 1'b0;
    redirect_i    = redir;
    redirect_pc_i = rpc;
    ready_i       = rdy;
    imem_gnt_i    = mem_gnt;
    got           = outstanding && (resp_wait == 0);
    imem_rvalid_i = got;
    imem_rdata_i  = got ? resp_data : $urandom;
    #1;
    exp_req = !outstanding && !m_have;
    check("imem_req", imem_req_o, exp_req);
    if (exp_req) check("imem_addr", imem_addr_o, m_pc);
    check("valid", valid_o, m_have && !redir);
    check("pc", pc_o, m_pc);
    check("pc_incr", pc_incr_o, m_pc + 32'd4);
    if (m_have) check("instr", instr_o, m_instr);
    fire        = m_have && rdy && !redir;
    granted_now = exp_req && mem_gnt;
    if (got) begin
      outstanding = 1'b0;
      if (resp_epoch == m_epoch && !redir) begin
        m_have  = 1'b1;
        m_instr = resp_data;
      end
    end else if (outstanding) begin
      resp_wait--;
    end
    if (granted_now) begin
      outstanding = 1'b1;
      resp_epoch  = m_epoch;
      grant_addr  = m_pc;
      glog.push_back(m_pc);
      resp_data   = mem_fixed ? mem_fixed_val : $urandom;
      resp_wait   = mem_lat - 1;
    end
    if (redir) begin
      m_pc   = rpc & ~32'h3;
      m_have = 1'b0;
      m_epoch++;
    end else if (fire) begin
      m_pc   = m_pc + 32'd4;
      m_have = 1'b0;
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst           = 1'b1;
      redirect_i    = 1'b0;
      ready_i       = 1'($urandom);
      imem_gnt_i    = 1'($urandom);
      imem_rvalid_i = 1'b0;
      #1;
      check("rst_req", imem_req_o, 1'b0);
      if (i > 0) begin
        check("rst_valid", valid_o, 1'b0);
        check("rst_pc", pc_o, RESET_PC);
        check("rst_pc_incr", pc_incr_o, RESET_PC + 32'd4);
        check("rst_instr", instr_o, 32'h0);
      end
    end
    m_pc        = RESET_PC;
    m_instr     = 32'h0;
    m_have      = 1'b0;
    m_epoch++;
    outstanding = 1'b0;
  endtask

  task automatic run_until_valid(input bit rdy, input int max);
    for (int i = 0; i < max && !m_have; i++) step(1'b0, 32'h0, rdy);
    check("tmo_valid", m_have, 1'b1);
  endtask

  task automatic step_until_grant(input bit rdy, input int max);
    granted_now = 1'b0;
    for (int i = 0; i < max && !granted_now; i++) step(1'b0, 32'h0, rdy);
    check("tmo_grant", granted_now, 1'b1);
  endtask

  initial begin
    rst = 1'b1; redirect_i = 1'b0; redirect_pc_i = 32'h0; ready_i = 1'b0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
    mem_gnt = 1'b1; mem_lat = 1; mem_fixed = 1'b1; mem_fixed_val = 32'h0000_0013;
    m_epoch = 0; outstanding = 1'b0; resp_wait = 0; m_have = 1'b0;
    do_reset(3);

    glog.delete();
    for (int i = 0; i < 9; i++) step(1'b0, 32'h0, 1'b1);
    check("seq_count", (glog.size() >= 3), 1'b1);
    if (glog.size() >= 3) begin
      check("seq_addr0", glog[0], 32'h0);
      check("seq_addr1", glog[1], 32'h4);
      check("seq_addr2", glog[2], 32'h8);
    end

    mem_fixed_val = 32'hDEAD_BEEF;
    step(1'b1, 32'h8, 1'b0);
    run_until_valid(1'b0, 12);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 32'h0, 1'b0);
      check("stall_instr", instr_o, 32'hDEAD_BEEF);
      check("stall_pc", pc_o, 32'h8);
      check("stall_req", imem_req_o, 1'b0);
    end
    step(1'b0, 32'h0, 1'b1);
    mem_lat = 4; mem_fixed_val = 32'h1111_1111;
    step_until_grant(1'b1, 6);
    check("stall_next", grant_addr, 32'hC);

    step(1'b1, 32'h100, 1'b1);
    mem_lat = 1; mem_fixed_val = 32'hCAFE_0100;
    glog.delete();
    run_until_valid(1'b0, 12);
    step(1'b0, 32'h0, 1'b0);
    check("rw_first_req", glog.size() > 0 ? glog[0] : 32'hFFFF_FFFF, 32'h100);
    check("rw_pc", pc_o, 32'h100);
    check("rw_instr", instr_o, 32'hCAFE_0100);

    step(1'b0, 32'h0, 1'b1);
    mem_lat = 2; mem_fixed_val = 32'h2222_2222;
    step_until_grant(1'b1, 6);
    for (int i = 0; i < 6 && !(outstanding && resp_wait == 0); i++) step(1'b0, 32'h0, 1'b1);
    check("rv_ready", imem_req_o == 1'b0 && outstanding && resp_wait == 0, 1'b1);
    step(1'b1, 32'h203, 1'b1);
    mem_fixed_val = 32'h3333_3333;
    glog.delete();
    run_until_valid(1'b0, 12);
    check("rv_req", glog.size() > 0 ? glog[0] : 32'hFFFF_FFFF, 32'h200);
    step(1'b1, 32'h203, 1'b1);
    check("rr_no_hs", valid_o, 1'b0);
    mem_fixed_val = 32'h4444_4444;
    glog.delete();
    run_until_valid(1'b0, 12);
    step(1'b0, 32'h0, 1'b0);
    check("rr_req", glog.size() > 0 ? glog[0] : 32'hFFFF_FFFF, 32'h200);
    check("rr_pc", pc_o, 32'h200);
    check("rr_instr", instr_o, 32'h4444_4444);

    step(1'b0, 32'h0, 1'b1);
    mem_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 32'h0, 1'b1);
      check("nognt_req", imem_req_o, 1'b1);
      check("nognt_addr", imem_addr_o, 32'h204);
    end
    mem_gnt = 1'b1; mem_lat = 1;
    step_until_grant(1'b1, 3);
    check("gnt_addr", grant_addr, 32'h204);
    run_until_valid(1'b0, 12);

    step(1'b1, 32'hFFFF_FFFC, 1'b0);
    run_until_valid(1'b0, 12);
    step(1'b0, 32'h0, 1'b0);
    check("wrap_pc", pc_o, 32'hFFFF_FFFC);
    check("wrap_incr", pc_incr_o, 32'h0);
    step(1'b0, 32'h0, 1'b1);
    mem_lat = 5;
    step_until_grant(1'b1, 4);
    check("wrap_next", grant_addr, 32'h0);
    step(1'b1, 32'h40, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    do_reset(2);
    mem_lat = 1;
    step_until_grant(1'b1, 4);
    check("rst_next", grant_addr, RESET_PC);

    mem_fixed = 1'b0;
    for (int i = 0; i < 400; i++) begin
      mem_gnt = ($urandom % 4) != 0;
      mem_lat = 1 + ($urandom % 3);
      if ($urandom % 200 == 0) begin
        do_reset(1 + ($urandom % 2));
      end else if ($urandom % 40 == 0) begin
        step(1'b1, 32'hFFFF_FFF0 | ($urandom % 16), 1'($urandom));
      end else begin
        step(($urandom % 8) == 0, $urandom, 1'($urandom));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
